aud_transport_ctrl: RTL and testbench
=====================================

Name: aud_transport_ctrl

Overview:
- Transport controller sitting directly upstream of the audio serial I/O stage (I2S-style codec shifter) and between that stage and the external 256K x 16 SRAM.
- Turns play/record/stop buttons into stage control: reset pulse, enable, RW, start/end address.
- Routes SRAM read data to the stage on playback and generates SRAM write strobes for captured samples on record.
- Tracks the length of the last recording.

Parameters:
REC_BASE, 18'd0, first SRAM word of the recording area
REC_MAX, 18'd240000, exclusive end address of the recording area (30 s at 8 kHz)
RST_CYC, 128, MCLK cycles aud_rst_n is held low on each arm (≥2 BCLK periods)
WR_PHASE, 26, BCLK falling edges after epoch start at which a record sample is written
WE_LEN, 4, MCLK cycles sram_we_n is held low per write

Ports:
MCLK  in  1  12.288 MHz master clock
reset  in  1  async active-low reset
btn_play  in  1  play request, level, asynchronous
btn_rec  in  1  record request, level, asynchronous
btn_stop  in  1  stop request, level, asynchronous
aud_bclk  in  1  BCLK from audio stage (MCLK/48, MCLK-synchronous)
aud_done  in  1  done from audio stage
aud_mem_current  in  18  current sample address from audio stage
aud_mem_data  in  16  captured sample from audio stage (valid only in its right-channel phase)
aud_rst_n  out  1  active-low reset to audio stage
aud_enable  out  1  enable to audio stage
aud_rw  out  1  0 = playback (read SRAM), 1 = record
aud_addr1  out  18  start address to audio stage
aud_addr2  out  18  exclusive end address to audio stage
aud_mem_q  out  16  SRAM read data to audio stage
sram_addr  out  18  SRAM address
sram_wdata  out  16  SRAM write data
sram_we_n  out  1  SRAM write enable, active low
sram_oe_n  out  1  SRAM output enable, active low
rec_end  out  18  exclusive end of last recording (REC_BASE = empty)
busy  out  1  high in ARM/PLAY/REC
mode  out  2  0 idle, 1 arm, 2 play, 3 rec

Behaviour:
Clock and reset:
- All logic on posedge MCLK, async active-low reset.
- Reset values:
  - aud_rst_n=0, aud_enable=0, aud_rw=0
  - aud_addr1=aud_addr2=REC_BASE, rec_end=REC_BASE
  - sram_we_n=1, sram_oe_n=1, sram_wdata=0
  - busy=0, mode=0, FSM=IDLE

Buttons:
- Each button passes through a 2-FF synchronizer and a rising-edge detector, giving a 1-cycle pulse.
- Priority when pulses coincide: stop > rec > play.

BCLK:
- aud_bclk is registered once. bclk_fall is asserted when the previous sample was 1 and the current sample is 0.

FSM:
- IDLE:
  - aud_rst_n=0, aud_enable=0.
  - rec pulse → latch aud_rw=1, aud_addr1=REC_BASE, aud_addr2=REC_MAX; go to ARM.
  - play pulse with rec_end≠REC_BASE → latch aud_rw=0, aud_addr1=REC_BASE, aud_addr2=rec_end; go to ARM.
  - play pulse with rec_end=REC_BASE → ignored.
- ARM:
  - Hold aud_rst_n=0 for RST_CYC cycles.
  - Then set aud_rst_n=1 and aud_enable=1 in the same cycle.
  - Go to PLAY or REC according to aud_rw.
  - Clear the epoch counter and set armed_wait=1.
- PLAY:
  - sram_oe_n=0, sram_addr=aud_mem_current, aud_mem_q = SRAM data bus (combinational).
  - aud_done=1 sampled after ≥2 bclk_fall since arm → IDLE.
  - stop pulse → IDLE immediately.
- REC:
  - sram_oe_n=1; aud_mem_q driven 0.
  - Epoch counter (6 bits) increments on bclk_fall.
  - Epoch counter is cleared to 0 on the first bclk_fall after arm (armed_wait cleared then).
  - Epoch counter is also cleared on any cycle where aud_mem_current differs from its registered copy.
  - When the epoch counter reaches WR_PHASE on a bclk_fall (one write per epoch):
    - sram_wdata ← aud_mem_data
    - sram_addr ← aud_mem_current
    - sram_we_n low for WE_LEN cycles; address and data held stable through the pulse and 1 cycle after.
  - aud_done → rec_end=REC_MAX; go to IDLE.
  - stop pulse → rec_end=aud_mem_current (only complete samples count); go to IDLE.
  - A write pulse in progress at stop completes its WE_LEN before sram_we_n returns high. FSM moves to IDLE immediately; the write unit finishes independently.
- Leaving PLAY or REC: aud_rst_n=0 and aud_enable=0 on the next cycle.

Other rules:
- stop in IDLE → no effect. rec or play pulses while busy → ignored (stop only).
- Address compares are unsigned 18-bit; no wrap: REC_MAX ≤ 2^18.
- Reset mid-operation returns to the reset values at once; any write pulse is aborted with sram_we_n=1.

Test Plan:
- Record then stop: rec pulse, 3 samples pass, stop → 3 writes at addresses 0,1,2, each with sram_we_n low 4 cycles; rec_end=3, mode back to 0.
- Write timing: model the audio stage; in REC, check each write happens at bclk_fall #26 after epoch start and captures its right-channel-phase data (e.g. 16'hA5C3 serial in → 16'hA5C3 written).
- Play: with rec_end=3, play pulse → aud_rst_n low 128 cycles, then aud_addr1=0, aud_addr2=3, aud_rw=0; sram_oe_n=0; stage's done → IDLE; no sram_we_n pulses.
- Empty play: after reset, play pulse → mode stays 0, aud_rst_n stays 0.
- Simultaneous buttons: rec and play rising edges in the same cycle in IDLE → REC. stop and rec rising edges in the same cycle during PLAY → IDLE.
- Async reset asserted during a write pulse → sram_we_n=1 immediately and every output at its reset value; rec_end=REC_BASE.

Source files
------------

// File: rtl/aud_transport_ctrl.sv
// Transport controller: turns play/record/stop buttons into control for the audio
// serial I/O stage and moves samples between that stage and the 256K x 16 SRAM.
`timescale 1ns/1ps
module aud_transport_ctrl #(
    parameter logic [17:0] REC_BASE = 18'd0,
    parameter logic [17:0] REC_MAX  = 18'd240000,
    parameter int          RST_CYC  = 128,
    parameter int          WR_PHASE = 26,
    parameter int          WE_LEN   = 4,
    parameter int          DATA_W   = 16
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              btn_play,
    input  logic              btn_rec,
    input  logic              btn_stop,
    input  logic              aud_bclk,
    input  logic              aud_done,
    input  logic [17:0]       aud_mem_current,
    input  logic [DATA_W-1:0] aud_mem_data,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              aud_rst_n,
    output logic              aud_enable,
    output logic              aud_rw,
    output logic [17:0]       aud_addr1,
    output logic [17:0]       aud_addr2,
    output logic [DATA_W-1:0] aud_mem_q,
    output logic [17:0]       sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [17:0]       rec_end,
    output logic              busy,
    output logic [1:0]        mode
);

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int WC_W = $clog2(WE_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2,
        S_REC  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          play_sync_q, play_sync_d;
    logic [2:0]          rec_sync_q, rec_sync_d;
    logic [2:0]          stop_sync_q, stop_sync_d;
    logic                bclk_q, bclk_d;
    logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [5:0]          epoch_q, epoch_d;
    logic                armed_wait_q, armed_wait_d;
    logic                wr_done_q, wr_done_d;
    logic [1:0]          fall_cnt_q, fall_cnt_d;
    logic [17:0]         cur_q, cur_d;
    logic [WC_W-1:0]     we_cnt_q, we_cnt_d;
    logic                we_n_q, we_n_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [17:0]         waddr_q, waddr_d;
    logic                rst_n_q, rst_n_d;
    logic                en_q, en_d;
    logic                rw_q, rw_d;
    logic [17:0]         addr1_q, addr1_d;
    logic [17:0]         addr2_q, addr2_d;
    logic [17:0]         rec_end_q, rec_end_d;
    logic                oe_n_q, oe_n_d;
    logic                busy_q, busy_d;
    logic [1:0]          mode_q, mode_d;

    logic play_pulse, rec_pulse, stop_pulse, bclk_fall, wr_start;

    assign play_pulse = play_sync_q[1] & ~play_sync_q[2];
    assign rec_pulse  = rec_sync_q[1]  & ~rec_sync_q[2];
    assign stop_pulse = stop_sync_q[1] & ~stop_sync_q[2];
    assign bclk_fall  = bclk_q & ~aud_bclk;

    always_comb begin
        state_d      = state_q;
        play_sync_d  = {play_sync_q[1:0], btn_play};
        rec_sync_d   = {rec_sync_q[1:0], btn_rec};
        stop_sync_d  = {stop_sync_q[1:0], btn_stop};
        bclk_d       = aud_bclk;
        rst_cnt_d    = rst_cnt_q;
        epoch_d      = epoch_q;
        armed_wait_d = armed_wait_q;
        wr_done_d    = wr_done_q;
        fall_cnt_d   = fall_cnt_q;
        cur_d        = aud_mem_current;
        we_cnt_d     = we_cnt_q;
        we_n_d       = we_n_q;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        rst_n_d      = rst_n_q;
        en_d         = en_q;
        rw_d         = rw_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        rec_end_d    = rec_end_q;
        wr_start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                rst_n_d = 1'b0;
                en_d    = 1'b0;
                // A coincident stop swallows rec/play even though it does nothing here.
                if (stop_pulse) begin
                    state_d = S_IDLE;
                end else if (rec_pulse) begin
                    rw_d      = 1'b1;
                    addr1_d   = REC_BASE;
                    addr2_d   = REC_MAX;
                    rst_cnt_d = '0;
                    state_d   = S_ARM;
                end else if (play_pulse && (rec_end_q != REC_BASE)) begin
                    rw_d      = 1'b0;
                    addr1_d   = REC_BASE;
                    addr2_d   = rec_end_q;
                    rst_cnt_d = '0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    rst_n_d      = 1'b1;
                    en_d         = 1'b1;
                    epoch_d      = '0;
                    armed_wait_d = 1'b1;
                    wr_done_d    = 1'b0;
                    fall_cnt_d   = '0;
                    state_d      = rw_q ? S_REC : S_PLAY;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_PLAY: begin
                if (bclk_fall && (fall_cnt_q != 2'd2)) begin
                    fall_cnt_d = fall_cnt_q + 2'd1;
                end
                if (stop_pulse || (aud_done && (fall_cnt_q == 2'd2))) begin
                    rst_n_d = 1'b0;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_REC: begin
                // Epoch restarts whenever the stage advances to the next sample address.
                if (aud_mem_current != cur_q) begin
                    epoch_d   = '0;
                    wr_done_d = 1'b0;
                end else if (bclk_fall) begin
                    if (armed_wait_q) begin
                        epoch_d      = '0;
                        armed_wait_d = 1'b0;
                        wr_done_d    = 1'b0;
                    end else begin
                        epoch_d = epoch_q + 6'd1;
                        if ((epoch_d == 6'(WR_PHASE)) && !wr_done_q) begin
                            wr_start  = 1'b1;
                            wr_done_d = 1'b1;
                        end
                    end
                end
                if (stop_pulse) begin
                    rec_end_d = aud_mem_current;
                    rst_n_d   = 1'b0;
                    en_d      = 1'b0;
                    state_d   = S_IDLE;
                end else if (aud_done) begin
                    rec_end_d = REC_MAX;
                    rst_n_d   = 1'b0;
                    en_d      = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Write strobe runs on its own so a pulse in flight at stop still completes.
        if (wr_start) begin
            we_n_d   = 1'b0;
            we_cnt_d = '0;
            wdata_d  = aud_mem_data;
            waddr_d  = aud_mem_current;
        end else if (!we_n_q) begin
            if (we_cnt_q == WC_W'(WE_LEN - 1)) begin
                we_n_d = 1'b1;
            end else begin
                we_cnt_d = we_cnt_q + WC_W'(1);
            end
        end

        mode_d = state_d;
        busy_d = (state_d != S_IDLE);
        oe_n_d = (state_d != S_PLAY);
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            play_sync_q  <= '0;
            rec_sync_q   <= '0;
            stop_sync_q  <= '0;
            bclk_q       <= 1'b0;
            rst_cnt_q    <= '0;
            epoch_q      <= '0;
            armed_wait_q <= 1'b0;
            wr_done_q    <= 1'b0;
            fall_cnt_q   <= '0;
            cur_q        <= '0;
            we_cnt_q     <= '0;
            we_n_q       <= 1'b1;
            wdata_q      <= '0;
            waddr_q      <= '0;
            rst_n_q      <= 1'b0;
            en_q         <= 1'b0;
            rw_q         <= 1'b0;
            addr1_q      <= REC_BASE;
            addr2_q      <= REC_BASE;
            rec_end_q    <= REC_BASE;
            oe_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            mode_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            play_sync_q  <= play_sync_d;
            rec_sync_q   <= rec_sync_d;
            stop_sync_q  <= stop_sync_d;
            bclk_q       <= bclk_d;
            rst_cnt_q    <= rst_cnt_d;
            epoch_q      <= epoch_d;
            armed_wait_q <= armed_wait_d;
            wr_done_q    <= wr_done_d;
            fall_cnt_q   <= fall_cnt_d;
            cur_q        <= cur_d;
            we_cnt_q     <= we_cnt_d;
            we_n_q       <= we_n_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            rst_n_q      <= rst_n_d;
            en_q         <= en_d;
            rw_q         <= rw_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            rec_end_q    <= rec_end_d;
            oe_n_q       <= oe_n_d;
            busy_q       <= busy_d;
            mode_q       <= mode_d;
        end
    end

    // Playback hands the stage's address and the SRAM bus straight through.
    assign sram_addr  = (state_q == S_PLAY) ? aud_mem_current : waddr_q;
    assign aud_mem_q  = (state_q == S_PLAY) ? sram_rdata : '0;
    assign sram_wdata = wdata_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign aud_rst_n  = rst_n_q;
    assign aud_enable = en_q;
    assign aud_rw     = rw_q;
    assign aud_addr1  = addr1_q;
    assign aud_addr2  = addr2_q;
    assign rec_end    = rec_end_q;
    assign busy       = busy_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
// Bench for aud_transport_ctrl: control vectors from a table, then record, play and
// reset-during-write sequences against a small model of the audio stage.
`timescale 1ns/1ps
module tb_aud_transport_ctrl;

    localparam logic [17:0] REC_MAX = 18'd240000;

    logic        MCLK = 1'b0;
    logic        reset = 1'b0;
    logic        btn_play = 1'b0, btn_rec = 1'b0, btn_stop = 1'b0;
    logic        aud_bclk = 1'b0;
    logic        aud_done = 1'b0;
    logic [17:0] aud_mem_current;
    logic [15:0] aud_mem_data;
    logic [15:0] sram_rdata = 16'h0000;
    logic        aud_rst_n, aud_enable, aud_rw;
    logic [17:0] aud_addr1, aud_addr2, sram_addr, rec_end;
    logic [15:0] aud_mem_q, sram_wdata;
    logic        sram_we_n, sram_oe_n, busy;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    // Audio stage model state
    int          bdiv = 0;
    logic        bclk_prev = 1'b0;
    int          sfc = 0;
    logic        sfirst = 1'b1;
    logic [17:0] stage_cur = 18'd0;
    int          pf = 0;
    logic        use_stage = 1'b0;
    logic [17:0] cur_man = 18'd0;

    aud_transport_ctrl dut (
        .MCLK(MCLK), .reset(reset),
        .btn_play(btn_play), .btn_rec(btn_rec), .btn_stop(btn_stop),
        .aud_bclk(aud_bclk), .aud_done(aud_done),
        .aud_mem_current(aud_mem_current), .aud_mem_data(aud_mem_data),
        .sram_rdata(sram_rdata),
        .aud_rst_n(aud_rst_n), .aud_enable(aud_enable), .aud_rw(aud_rw),
        .aud_addr1(aud_addr1), .aud_addr2(aud_addr2), .aud_mem_q(aud_mem_q),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .rec_end(rec_end), .busy(busy), .mode(mode)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [15:0] pat(input int idx);
        case (idx)
            0:       return 16'hA5C3;
            1:       return 16'h1234;
            2:       return 16'h8001;
            default: return 16'h7E7E;
        endcase
    endfunction

    assign aud_mem_current = use_stage ? stage_cur : cur_man;

    // Right-channel phase of each 32-BCLK epoch carries the sample; junk elsewhere.
    always_comb begin
        aud_mem_data = (sfc >= 17) ? pat(int'(stage_cur)) : 16'hDEAD;
    end

    always @(posedge MCLK) begin
        bclk_prev <= aud_bclk;
        if (bdiv == 23) begin
            bdiv     <= 0;
            aud_bclk <= ~aud_bclk;
        end else begin
            bdiv <= bdiv + 1;
        end
        if (!aud_enable) pf <= 0;
        else if (bclk_prev && !aud_bclk && pf < 1000) pf <= pf + 1;
        if (!(use_stage && aud_enable && aud_rw)) begin
            sfirst    <= 1'b1;
            sfc       <= 0;
            stage_cur <= 18'd0;
        end else if (bclk_prev && !aud_bclk) begin
            if (sfirst) begin
                sfirst <= 1'b0;
                sfc    <= 0;
            end else if (sfc == 31) begin
                sfc       <= 0;
                stage_cur <= stage_cur + 18'd1;
            end else begin
                sfc <= sfc + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        play, rec, stop;
        logic [17:0] cur;
        int          cyc;
        logic [1:0]  mode;
        logic        rst_n, en, rw, oe_n;
        logic [17:0] addr2, rec_end;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic r, input logic s,
                                input logic [17:0] cur, input int cyc, input logic [1:0] md,
                                input logic rn, input logic en, input logic rw, input logic oe,
                                input logic [17:0] a2, input logic [17:0] re);
        vec_t v;
        v.play = p; v.rec = r; v.stop = s; v.cur = cur; v.cyc = cyc; v.mode = md;
        v.rst_n = rn; v.en = en; v.rw = rw; v.oe_n = oe; v.addr2 = a2; v.rec_end = re;
        return v;
    endfunction

    vec_t        vt[15];
    logic        we_prev, stop_sent, fin, io_done;
    logic [17:0] w_addr;
    logic [15:0] w_data;
    int          nwr, low_len, quiet, n, low_cnt;

    initial begin
        //           p    r    s    cur     cyc  mode rn   en   rw   oe   addr2    rec_end
        vt[0]  = mk(1'b0,1'b0,1'b0,18'd0, 2,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd0,   18'd0);
        vt[1]  = mk(1'b1,1'b0,1'b0,18'd0, 4,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd0,   18'd0);
        vt[2]  = mk(1'b0,1'b0,1'b0,18'd0, 2,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd0,   18'd0);
        vt[3]  = mk(1'b1,1'b1,1'b0,18'd0, 4,   2'd1,1'b0,1'b0,1'b1,1'b1,REC_MAX, 18'd0);
        vt[4]  = mk(1'b0,1'b0,1'b0,18'd0, 130, 2'd3,1'b1,1'b1,1'b1,1'b1,REC_MAX, 18'd0);
        vt[5]  = mk(1'b0,1'b0,1'b1,18'd7, 4,   2'd0,1'b0,1'b0,1'b1,1'b1,REC_MAX, 18'd7);
        vt[6]  = mk(1'b0,1'b0,1'b0,18'd7, 2,   2'd0,1'b0,1'b0,1'b1,1'b1,REC_MAX, 18'd7);
        vt[7]  = mk(1'b1,1'b0,1'b0,18'd7, 4,   2'd1,1'b0,1'b0,1'b0,1'b1,18'd7,   18'd7);
        vt[8]  = mk(1'b0,1'b0,1'b0,18'd7, 130, 2'd2,1'b1,1'b1,1'b0,1'b0,18'd7,   18'd7);
        vt[9]  = mk(1'b0,1'b1,1'b0,18'd7, 4,   2'd2,1'b1,1'b1,1'b0,1'b0,18'd7,   18'd7);
        vt[10] = mk(1'b0,1'b0,1'b0,18'd7, 2,   2'd2,1'b1,1'b1,1'b0,1'b0,18'd7,   18'd7);
        vt[11] = mk(1'b0,1'b1,1'b1,18'd7, 4,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd7,   18'd7);
        vt[12] = mk(1'b0,1'b0,1'b0,18'd7, 4,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd7,   18'd7);
        vt[13] = mk(1'b0,1'b0,1'b1,18'd7, 4,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd7,   18'd7);
        vt[14] = mk(1'b0,1'b0,1'b0,18'd7, 2,   2'd0,1'b0,1'b0,1'b0,1'b1,18'd7,   18'd7);

        repeat (3) @(negedge MCLK);
        chk("rst_we_n", 32'(sram_we_n), 32'(1));
        chk("rst_wdata", 32'(sram_wdata), 32'(0));
        chk("rst_addr1", 32'(aud_addr1), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            btn_play = vt[i].play; btn_rec = vt[i].rec; btn_stop = vt[i].stop;
            cur_man  = vt[i].cur;
            repeat (vt[i].cyc) @(negedge MCLK);
            chk($sformatf("v%0d_mode", i), 32'(mode), 32'(vt[i].mode));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].mode != 2'd0));
            chk($sformatf("v%0d_rst_n", i), 32'(aud_rst_n), 32'(vt[i].rst_n));
            chk($sformatf("v%0d_enable", i), 32'(aud_enable), 32'(vt[i].en));
            chk($sformatf("v%0d_rw", i), 32'(aud_rw), 32'(vt[i].rw));
            chk($sformatf("v%0d_oe_n", i), 32'(sram_oe_n), 32'(vt[i].oe_n));
            chk($sformatf("v%0d_addr2", i), 32'(aud_addr2), 32'(vt[i].addr2));
            chk($sformatf("v%0d_rec_end", i), 32'(rec_end), 32'(vt[i].rec_end));
        end
        btn_play = 1'b0; btn_rec = 1'b0; btn_stop = 1'b0;

        // Record three samples, stop early in the fourth.
        use_stage = 1'b1;
        btn_rec = 1'b1;
        stop_sent = 1'b0; fin = 1'b0; io_done = 1'b0; we_prev = 1'b1;
        nwr = 0; low_len = 0; quiet = 0;
        w_addr = '0; w_data = '0;
        for (int c = 0; c < 9000 && !fin; c++) begin
            @(negedge MCLK);
            if (c == 6) btn_rec = 1'b0;
            if (we_prev && !sram_we_n) begin
                w_addr = sram_addr; w_data = sram_wdata; low_len = 1;
                chk("wr_phase", 32'(sfc), 32'(26));
                chk("wr_addr", 32'(sram_addr), 32'(nwr));
                chk("wr_data", 32'(sram_wdata), 32'(pat(nwr)));
            end else if (!sram_we_n) begin
                low_len++;
                chk("wr_hold_addr", 32'(sram_addr), 32'(w_addr));
                chk("wr_hold_data", 32'(sram_wdata), 32'(w_data));
            end else if (!we_prev) begin
                chk("we_len", 32'(low_len), 32'(4));
                chk("wr_after_addr", 32'(sram_addr), 32'(w_addr));
                chk("wr_after_data", 32'(sram_wdata), 32'(w_data));
                nwr++;
            end
            we_prev = sram_we_n;
            if (!io_done && stage_cur == 18'd1 && sfc == 10) begin
                chk("rec_mode", 32'(mode), 32'(3));
                chk("rec_oe_n", 32'(sram_oe_n), 32'(1));
                chk("rec_mem_q", 32'(aud_mem_q), 32'(0));
                io_done = 1'b1;
            end
            if (!stop_sent && stage_cur == 18'd3 && sfc == 5) begin
                btn_stop = 1'b1;
                stop_sent = 1'b1;
            end
            if (stop_sent && mode == 2'd0 && sram_we_n) begin
                quiet++;
                if (quiet > 8) fin = 1'b1;
            end
        end
        btn_stop = 1'b0;
        chk("rec_finished", 32'(fin), 32'(1));
        chk("wr_count", 32'(nwr), 32'(3));
        chk("rec_end_after_stop", 32'(rec_end), 32'(3));
        chk("rec_exit_rst_n", 32'(aud_rst_n), 32'(0));

        // Play back the recording.
        use_stage = 1'b0; cur_man = 18'd2; sram_rdata = 16'h5A5A;
        btn_play = 1'b1;
        n = 0;
        while (mode != 2'd1 && n < 20) begin @(negedge MCLK); n++; end
        chk("play_arm", 32'(mode), 32'(1));
        btn_play = 1'b0;
        n = 0;
        while (!aud_rst_n && n < 300) begin n++; @(negedge MCLK); end
        chk("arm_len", 32'(n), 32'(128));
        chk("play_mode", 32'(mode), 32'(2));
        chk("play_enable", 32'(aud_enable), 32'(1));
        chk("play_rw", 32'(aud_rw), 32'(0));
        chk("play_addr1", 32'(aud_addr1), 32'(0));
        chk("play_addr2", 32'(aud_addr2), 32'(3));
        chk("play_oe_n", 32'(sram_oe_n), 32'(0));
        chk("play_sram_addr", 32'(sram_addr), 32'(2));
        chk("play_mem_q", 32'(aud_mem_q), 32'(16'h5A5A));
        aud_done = 1'b1;
        low_cnt = 0;
        repeat (2) begin @(negedge MCLK); if (!sram_we_n) low_cnt++; end
        chk("done_guard", 32'(mode), 32'(2));
        n = 0;
        while (mode != 2'd0 && n < 300) begin
            @(negedge MCLK);
            if (!sram_we_n) low_cnt++;
            n++;
        end
        chk("play_done", 32'(mode), 32'(0));
        chk("play_falls_ge2", 32'(pf >= 2), 32'(1));
        chk("play_no_writes", 32'(low_cnt), 32'(0));
        chk("play_exit_rst_n", 32'(aud_rst_n), 32'(0));
        aud_done = 1'b0;

        // Asynchronous reset in the middle of a write pulse.
        use_stage = 1'b1;
        btn_rec = 1'b1;
        n = 0;
        while (sram_we_n && n < 3000) begin
            @(negedge MCLK);
            n++;
            if (n == 6) btn_rec = 1'b0;
        end
        btn_rec = 1'b0;
        chk("d_write_seen", 32'(sram_we_n), 32'(0));
        reset = 1'b0;
        #1;
        chk("d_we_n", 32'(sram_we_n), 32'(1));
        chk("d_mode", 32'(mode), 32'(0));
        chk("d_busy", 32'(busy), 32'(0));
        chk("d_rst_n", 32'(aud_rst_n), 32'(0));
        chk("d_enable", 32'(aud_enable), 32'(0));
        chk("d_rw", 32'(aud_rw), 32'(0));
        chk("d_addr2", 32'(aud_addr2), 32'(0));
        chk("d_rec_end", 32'(rec_end), 32'(0));
        chk("d_oe_n", 32'(sram_oe_n), 32'(1));
        chk("d_wdata", 32'(sram_wdata), 32'(0));
        @(negedge MCLK);
        reset = 1'b1;
        repeat (4) @(negedge MCLK);
        chk("d_after_we_n", 32'(sram_we_n), 32'(1));
        chk("d_after_mode", 32'(mode), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, want finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
